// File: rtl/spi_exe_unit_n.sv
// SPI-slave execution unit: shifts in A, B, OPER, runs one ALU op, shifts out {result, OF, SF, ZF, PF, pad}.
// Optional SPI_EXE_STATUS_EN: 8-bit frame counter carried in the low pad byte (requires PAD >= 8).
module spi_exe_unit_n #(
  parameter int WIDTH  = 8,
  parameter int OPER_W = 4,
  parameter int PAD    = 16
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_busy,
  output logic o_frame_done,
  output logic o_err
);

  localparam int OUT_BITS = WIDTH + 4 + PAD;
  localparam int CNT_W    = $clog2(OUT_BITS + 1);
  localparam int SH_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_OP, EXEC, SHIFT_OUT, WAIT_CS} state_t;

  state_t               state;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [OPER_W-1:0]    opcode;
  logic [WIDTH-1:0]     sh_in;
  logic [OUT_BITS-1:0]  out_sr;
  logic [CNT_W-1:0]     bit_cnt;
  logic [WIDTH-1:0]     word_in;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_of;
  logic [PAD-1:0]       pad_bits;

`ifdef SPI_EXE_STATUS_EN
  logic [7:0] frame_cnt;
  assign pad_bits = PAD'(frame_cnt + 8'd1);
`else
  assign pad_bits = '0;
`endif

  assign word_in = {sh_in[WIDTH-2:0], i_mosi};

  // Overflow is only meaningful for the signed add/subtract opcodes.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (opcode)
      OPER_W'(0): begin
        alu_res = a + b;
        alu_of  = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OPER_W'(1): begin
        alu_res = a - b;
        alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OPER_W'(2): alu_res = a & b;
      OPER_W'(3): alu_res = a | b;
      OPER_W'(4): alu_res = a ^ b;
      OPER_W'(5): alu_res = ~a;
      OPER_W'(6): alu_res = a << b[SH_W-1:0];
      OPER_W'(7): alu_res = a >> b[SH_W-1:0];
      default:    alu_res = '0;
    endcase
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      state        <= IDLE;
      a            <= '0;
      b            <= '0;
      opcode       <= '0;
      sh_in        <= '0;
      out_sr       <= '0;
      bit_cnt      <= '0;
      o_miso       <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
`ifdef SPI_EXE_STATUS_EN
      frame_cnt    <= '0;
`endif
    end else begin
      o_miso       <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_cs) begin
            sh_in   <= {{(WIDTH-1){1'b0}}, i_mosi};
            bit_cnt <= CNT_W'(1);
            o_err   <= 1'b0;
            o_busy  <= 1'b1;
            state   <= LOAD_A;
          end
        end
        // Words are committed only when complete, so an abort leaves prior values intact.
        LOAD_A, LOAD_B, LOAD_OP: begin
          if (i_cs) begin
            state   <= IDLE;
            o_err   <= 1'b1;
            bit_cnt <= '0;
          end else begin
            sh_in  <= word_in;
            o_busy <= 1'b1;
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
              bit_cnt <= '0;
              if (state == LOAD_A) begin
                a     <= word_in;
                state <= LOAD_B;
              end else if (state == LOAD_B) begin
                b     <= word_in;
                state <= LOAD_OP;
              end else begin
                opcode <= word_in[WIDTH-1 -: OPER_W];
                state  <= EXEC;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        EXEC: begin
          if (i_cs) begin
            state   <= IDLE;
            o_err   <= 1'b1;
            bit_cnt <= '0;
          end else begin
            out_sr  <= {alu_res, alu_of, alu_res[WIDTH-1], (alu_res == '0), ~^alu_res, pad_bits};
            bit_cnt <= '0;
            o_busy  <= 1'b1;
            state   <= SHIFT_OUT;
          end
        end
        SHIFT_OUT: begin
          if (i_cs) begin
            state   <= IDLE;
            o_err   <= 1'b1;
            bit_cnt <= '0;
          end else begin
            o_miso <= out_sr[OUT_BITS-1];
            out_sr <= out_sr << 1;
            o_busy <= 1'b1;
            if (bit_cnt == CNT_W'(OUT_BITS - 1)) begin
              o_frame_done <= 1'b1;
              bit_cnt      <= '0;
              state        <= WAIT_CS;
`ifdef SPI_EXE_STATUS_EN
              frame_cnt    <= frame_cnt + 8'd1;
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        WAIT_CS: begin
          if (i_cs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_exe_unit_n.sv
// Randomised bench for spi_exe_unit_n with a frame-level reference model and per-edge output comparison.
module tb_spi_exe_unit_n;

  localparam int W   = 8;
  localparam int OW  = 4;
  localparam int PAD = 16;
  localparam int OB  = W + 4 + PAD;
`ifdef SPI_EXE_STATUS_EN
  localparam logic [OB-1:0] PAD_MASK = {{(OB-8){1'b1}}, 8'h00};
`else
  localparam logic [OB-1:0] PAD_MASK = {OB{1'b1}};
`endif

  logic i_sclk = 1'b0;
  logic i_rst, i_cs, i_mosi;
  logic o_miso, o_busy, o_frame_done, o_err;

  int compared   = 0;
  int mismatched = 0;

  logic exp_miso = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  bit   check_en = 1'b0;
  int   model_cnt = 0;
  logic model_err = 1'b0;
  logic [OB-1:0] captured;

  spi_exe_unit_n #(.WIDTH(W), .OPER_W(OW), .PAD(PAD)) dut (
    .i_sclk      (i_sclk),
    .i_rst       (i_rst),
    .i_cs        (i_cs),
    .i_mosi      (i_mosi),
    .o_miso      (o_miso),
    .o_busy      (o_busy),
    .o_frame_done(o_frame_done),
    .o_err       (o_err)
  );

  always #5 i_sclk = ~i_sclk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge i_sclk) begin
    if (check_en) begin
      checkOutput("o_miso", 64'(o_miso), 64'(exp_miso));
      checkOutput("o_busy", 64'(o_busy), 64'(exp_busy));
      checkOutput("o_frame_done", 64'(o_frame_done), 64'(exp_done));
      checkOutput("o_err", 64'(o_err), 64'(exp_err));
    end
  end

  // Drive inputs away from the edge, then publish what the outputs must be after it.
  task automatic applyStimulus(input logic cs, input logic mosi, input logic rst,
                               input logic em, input logic eb, input logic ed);
    @(negedge i_sclk);
    i_cs   = cs;
    i_mosi = mosi;
    i_rst  = rst;
    @(posedge i_sclk);
    #1;
    exp_miso = em;
    exp_busy = eb;
    exp_done = ed;
    exp_err  = model_err;
    check_en = 1'b1;
  endtask

  function automatic logic [OB-1:0] model_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [W-1:0] oper, input int cnt);
    int ua, ub, sa, sb, s, r, sh, op, m;
    int of;
    longint f;
    m  = 1 << W;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sh = ub % W;
    op = int'(oper) >> (W - OW);
    of = 0;
    case (op)
      0: begin s = sa + sb; r = (ua + ub) % m; of = (s >= m / 2 || s < -m / 2) ? 1 : 0; end
      1: begin s = sa - sb; r = (ua - ub + m) % m; of = (s >= m / 2 || s < -m / 2) ? 1 : 0; end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = m - 1 - ua;
      6: r = (ua << sh) % m;
      7: r = ua >> sh;
      default: r = 0;
    endcase
    f = longint'(r);
    f = (f << 1) | longint'(of);
    f = (f << 1) | ((r >= m / 2) ? 64'd1 : 64'd0);
    f = (f << 1) | ((r == 0) ? 64'd1 : 64'd0);
    f = (f << 1) | (($countones(r) % 2 == 0) ? 64'd1 : 64'd0);
    f = f << PAD;
`ifdef SPI_EXE_STATUS_EN
    f = f | longint'((cnt + 1) % 256);
`else
    if (cnt < 0) f = 0;
`endif
    return f[OB-1:0];
  endfunction

  // abort_at: input bit index at which CS rises (-1 none); reset_at: output bit index at which reset fires.
  task automatic runFrame(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] oper,
                          input int abort_at, input int reset_at, input int wait_edges);
    logic [3*W-1:0] bits;
    logic [OB-1:0]  exp;
    bits = {a, b, oper};
    for (int i = 0; i < 3 * W; i++) begin
      if (i == abort_at) begin
        model_err = 1'b1;
        applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (i == 0) model_err = 1'b0;
      applyStimulus(1'b0, bits[3*W-1-i], 1'b0, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
    exp = model_frame(a, b, oper, model_cnt);
    captured = '0;
    for (int k = 0; k < OB; k++) begin
      if (k == reset_at) begin
        model_err = 1'b0;
        model_cnt = 0;
        applyStimulus(1'b0, 1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        return;
      end
      applyStimulus(1'b0, 1'($urandom), 1'b0, exp[OB-1-k], 1'b1, (k == OB - 1));
      captured = {captured[OB-2:0], o_miso};
    end
    model_cnt = (model_cnt + 1) % 256;
    checkOutput("frame", 64'(captured), 64'(exp));
    for (int w = 0; w < wait_edges; w++)
      applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    i_rst  = 1'b1;
    i_cs   = 1'b1;
    i_mosi = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    runFrame(8'h7F, 8'h01, 8'h00, -1, -1, 0);
    checkOutput("add_overflow_lit", 64'(captured & PAD_MASK), 64'h80C0000);
    runFrame(8'h05, 8'h05, 8'h10, -1, -1, 0);
    checkOutput("sub_zero_lit", 64'(captured & PAD_MASK), 64'h0030000);
    runFrame(8'h81, 8'h01, 8'h60, -1, -1, 0);
    checkOutput("shl_lit", 64'(captured & PAD_MASK), 64'h0200000);
    runFrame(8'($urandom), 8'($urandom), 8'hF0, -1, -1, 0);
    checkOutput("bad_opcode_lit", 64'(captured & PAD_MASK), 64'h0030000);

    runFrame(8'hAA, 8'h55, 8'h00, 12, -1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    runFrame(8'h01, 8'h01, 8'h00, -1, -1, 0);
    checkOutput("add_after_abort_lit", 64'(captured & PAD_MASK), 64'h0200000);

    runFrame(8'h3C, 8'h0F, 8'h40, -1, -1, 20);
    runFrame(8'h12, 8'h34, 8'h20, -1, 10, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      runFrame(8'($urandom), 8'($urandom), {4'($urandom_range(0, 15)), 4'($urandom)},
               ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3 * W - 1)) : -1,
               -1, int'($urandom_range(0, 3)));
    end

`ifdef SPI_EXE_STATUS_EN
    model_cnt = 0;
    model_err = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 256; j++) begin
      runFrame(8'($urandom), 8'($urandom), {4'($urandom_range(0, 7)), 4'h0}, -1, -1, 0);
      checkOutput("pad_counter", 64'(captured[7:0]), 64'(8'(j + 1)));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
